// File: rtl/monocular_link_pkg.sv
// rtl/monocular_link_pkg.sv - shared types and constants for the analyser tx scheduler (ANALYSER_TX_CHECKSUM_EN adds the CSUM byte)
package monocular_link_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        TIME = 3'd2,
        SMP  = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5
    } tx_state_t;

    localparam logic [7:0] HEADER_DEFAULT     = 8'hA5;
    localparam int         TIME_BYTES_DEFAULT = 4;

    // Bytes on the wire per packet: header + timestamp + sample (+ checksum)
    function automatic int packet_len(input int time_bytes);
`ifdef ANALYSER_TX_CHECKSUM_EN
        return time_bytes + 3;
`else
        return time_bytes + 2;
`endif
    endfunction

    localparam int PACKET_LEN_DEFAULT = packet_len(TIME_BYTES_DEFAULT);

endpackage

// File: rtl/tx_byte_mux.sv
// rtl/tx_byte_mux.sv - combinational select of the outgoing packet byte
module tx_byte_mux
    import monocular_link_pkg::*;
#(
    parameter logic [7:0] HEADER     = HEADER_DEFAULT,
    parameter int         TIME_BYTES = TIME_BYTES_DEFAULT,
    parameter int         IDX_W      = 2
) (
    input  tx_state_t               state,
    input  logic [IDX_W-1:0]        byte_idx,
    input  logic [8*TIME_BYTES-1:0] time_lat,
    input  logic [7:0]              sample_lat,
    input  logic [7:0]              csum,
    output logic [7:0]              tx_data
);

    logic [7:0] time_byte;

    // Timestamp byte picked MSB first: index 0 is the top byte
    always_comb begin
        time_byte = 8'h00;
        for (int i = 0; i < TIME_BYTES; i++) begin
            if (byte_idx == IDX_W'(i)) begin
                time_byte = time_lat[8*(TIME_BYTES-1-i) +: 8];
            end
        end
    end

    // Byte per state; zero whenever nothing is being offered
    always_comb begin
        tx_data = 8'h00;
        case (state)
            HDR:     tx_data = HEADER;
            TIME:    tx_data = time_byte;
            SMP:     tx_data = sample_lat;
            CSUM:    tx_data = csum;
            default: tx_data = 8'h00;
        endcase
    end

endmodule

// File: rtl/analyser_tx_scheduler.sv
// rtl/analyser_tx_scheduler.sv - serialises analyser events into byte packets for the UART (ANALYSER_TX_CHECKSUM_EN adds a trailing XOR byte)
module analyser_tx_scheduler
    import monocular_link_pkg::*;
#(
    parameter logic [7:0] HEADER     = HEADER_DEFAULT,
    parameter int         TIME_BYTES = TIME_BYTES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    new_data,
    input  logic [8*TIME_BYTES-1:0] time_in,
    input  logic [7:0]              sample_in,
    output logic                    data_sent,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic [7:0]              dropped
);

    localparam int              IDX_W    = (TIME_BYTES > 1) ? $clog2(TIME_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TIME_BYTES - 1);

    tx_state_t               state;
    tx_state_t               state_next;
    logic [IDX_W-1:0]        byte_idx;
    logic [8*TIME_BYTES-1:0] time_lat;
    logic [7:0]              sample_lat;
    logic [7:0]              csum_byte;
    logic                    idle_like;
    logic                    capture;
    logic                    drop;
    logic                    xfer;

    // DONE accepts a new event just like IDLE so packets can run back to back
    assign idle_like = (state == IDLE) || (state == DONE);
    assign capture   = idle_like && enable && new_data;
    assign drop      = !idle_like && enable && new_data;
    assign xfer      = tx_valid && tx_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: advance only on an accepted byte, so stalls hold the current byte
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (capture) state_next = HDR;
            HDR:  if (xfer) state_next = TIME;
            TIME: if (xfer && (byte_idx == LAST_IDX)) state_next = SMP;
`ifdef ANALYSER_TX_CHECKSUM_EN
            SMP:  if (xfer) state_next = CSUM;
            CSUM: if (xfer) state_next = DONE;
`else
            SMP:  if (xfer) state_next = DONE;
`endif
            DONE: state_next = capture ? HDR : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state alone, so they are glitch-free of the inputs
    always_comb begin
        tx_valid  = (state == HDR) || (state == TIME) || (state == SMP) || (state == CSUM);
        data_sent = (state == DONE);
        busy      = (state != IDLE);
    end

    // Event latch and timestamp byte index; a drop never touches the latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            time_lat   <= '0;
            sample_lat <= 8'h00;
            byte_idx   <= '0;
        end else if (capture) begin
            time_lat   <= time_in;
            sample_lat <= sample_in;
            byte_idx   <= '0;
        end else if (xfer && (state == TIME)) begin
            byte_idx <= byte_idx + 1'b1;
        end
    end

    // Saturating lost-event counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dropped <= 8'h00;
        end else if (drop && (dropped != 8'hFF)) begin
            dropped <= dropped + 8'h01;
        end
    end

`ifdef ANALYSER_TX_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of every byte accepted so far in this packet, header included
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= 8'h00;
        end else if (capture) begin
            csum <= 8'h00;
        end else if (xfer) begin
            csum <= csum ^ tx_data;
        end
    end

    assign csum_byte = csum;
`else
    assign csum_byte = 8'h00;
`endif

    tx_byte_mux #(
        .HEADER     (HEADER),
        .TIME_BYTES (TIME_BYTES),
        .IDX_W      (IDX_W)
    ) u_tx_byte_mux (
        .state      (state),
        .byte_idx   (byte_idx),
        .time_lat   (time_lat),
        .sample_lat (sample_lat),
        .csum       (csum_byte),
        .tx_data    (tx_data)
    );

endmodule

// File: tb/tb_analyser_tx_scheduler.sv
// tb/tb_analyser_tx_scheduler.sv - self-checking bench for analyser_tx_scheduler
`timescale 1ns/1ps
module tb_analyser_tx_scheduler;

`ifdef ANALYSER_TX_CHECKSUM_EN
    localparam int PKT_LEN = 7;
`else
    localparam int PKT_LEN = 6;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        new_data = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] time_in = 32'h0;
    logic [7:0]  sample_in = 8'h0;
    logic        data_sent;
    logic        tx_valid;
    logic        busy;
    logic [7:0]  tx_data;
    logic [7:0]  dropped;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  sb_data[$];
    bit          sb_last[$];
    bit          exp_sent = 1'b0;
    int          exp_dropped = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h0;
    int          bytes_in_pkt = 0;
    int          drain_cycles = 0;

    typedef struct {
        logic [31:0] t;
        logic [7:0]  s;
        int          mode;
        logic [31:0] exp_dropped_after;
        logic        exp_busy_after;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    analyser_tx_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .new_data  (new_data),
        .time_in   (time_in),
        .sample_in (sample_in),
        .data_sent (data_sent),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .dropped   (dropped)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: check outputs at this negedge, model the coming edge, advance to next negedge
    task automatic step();
        bit         hs;
        logic [7:0] e;
        bit         l;
        logic [7:0] pk[$];
        logic [7:0] x;
        chk("data_sent", 32'(data_sent), 32'(exp_sent));
        chk("dropped", 32'(dropped), 32'(exp_dropped));
        if (prev_stall) begin
            chk("hold_valid", 32'(tx_valid), 32'd1);
            chk("hold_data", 32'(tx_data), 32'(prev_data));
        end
        if (enable && new_data && rst) begin
            if (sb_data.size() == 0) begin
                pk.push_back(8'hA5);
                for (int i = 3; i >= 0; i--) pk.push_back(time_in[8*i +: 8]);
                pk.push_back(sample_in);
`ifdef ANALYSER_TX_CHECKSUM_EN
                x = 8'h00;
                foreach (pk[i]) x = x ^ pk[i];
                pk.push_back(x);
`endif
                foreach (pk[i]) begin
                    sb_data.push_back(pk[i]);
                    sb_last.push_back(i == pk.size() - 1);
                end
            end else if (exp_dropped < 255) begin
                exp_dropped++;
            end
        end
        hs = tx_valid && tx_ready;
        exp_sent = 1'b0;
        if (hs) begin
            if (sb_data.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got %0h expected none", tx_data);
            end else begin
                e = sb_data.pop_front();
                l = sb_last.pop_front();
                chk("tx_data", 32'(tx_data), 32'(e));
                bytes_in_pkt++;
                if (l) begin
                    exp_sent = 1'b1;
                    chk("pkt_len", 32'(bytes_in_pkt), 32'(PKT_LEN));
                    bytes_in_pkt = 0;
                end
            end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        @(negedge clk);
    endtask

    task automatic start(input logic [31:0] t, input logic [7:0] s);
        time_in   = t;
        sample_in = s;
        enable    = 1'b1;
        new_data  = 1'b1;
        step();
        new_data  = 1'b0;
        chk("first_valid", 32'(tx_valid), 32'd1);
        chk("first_busy", 32'(busy), 32'd1);
    endtask

    // Run until data_sent is visible; mode 0 ready=1, 1 toggling, 2 random
    task automatic drain(input int mode);
        bit done;
        done = 1'b0;
        drain_cycles = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            step();
            drain_cycles++;
            if (data_sent) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got no data_sent expected pulse");
        end
    endtask

    initial begin
        vecs[0] = '{t: 32'h0000_0003, s: 8'd69,  mode: 0, exp_dropped_after: 32'd0, exp_busy_after: 1'b0};
        vecs[1] = '{t: 32'h1234_5678, s: 8'd100, mode: 1, exp_dropped_after: 32'd0, exp_busy_after: 1'b0};
        vecs[2] = '{t: 32'hDEAD_BEEF, s: 8'hFF,  mode: 2, exp_dropped_after: 32'd0, exp_busy_after: 1'b0};
        vecs[3] = '{t: 32'hFFFF_FFFF, s: 8'h00,  mode: 1, exp_dropped_after: 32'd0, exp_busy_after: 1'b0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_data_sent", 32'(data_sent), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dropped", 32'(dropped), 32'd0);
        rst = 1'b1;
        step();

        // Basic packet, no bubbles
        tx_ready = 1'b1;
        start(32'h0000_0003, 8'd69);
        drain(0);
        chk("basic_cycles", 32'(drain_cycles), 32'(PKT_LEN));
        step();
        chk("basic_idle", 32'(busy), 32'd0);

        // Table of packets under different ready patterns
        for (int v = 0; v < 4; v++) begin
            start(vecs[v].t, vecs[v].s);
            drain(vecs[v].mode);
            step();
            chk("vec_busy_after", 32'(busy), 32'(vecs[v].exp_busy_after));
            chk("vec_dropped_after", 32'(dropped), vecs[v].exp_dropped_after);
        end

        // Drop during TIME keeps the first event
        tx_ready = 1'b1;
        start(32'h1122_3344, 8'h55);
        step();
        time_in   = 32'hCAFE_BABE;
        sample_in = 8'h77;
        new_data  = 1'b1;
        step();
        new_data  = 1'b0;
        chk("drop_one", 32'(dropped), 32'd1);
        drain(0);
        step();

        // Capture in DONE goes straight to HDR
        start(32'h0102_0304, 8'h05);
        drain(0);
        time_in   = 32'hA0B0_C0D0;
        sample_in = 8'hE0;
        new_data  = 1'b1;
        step();
        new_data  = 1'b0;
        chk("done_cap_valid", 32'(tx_valid), 32'd1);
        chk("done_cap_hdr", 32'(tx_data), 32'hA5);
        chk("done_cap_busy", 32'(busy), 32'd1);
        drain(0);
        step();

        // 300 drops while stalled in HDR saturate the counter
        tx_ready  = 1'b0;
        time_in   = 32'h0000_0042;
        sample_in = 8'h24;
        new_data  = 1'b1;
        for (int i = 0; i < 301; i++) step();
        new_data  = 1'b0;
        chk("drop_sat", 32'(dropped), 32'd255);
        drain(0);
        step();

        // Reset mid-TIME aborts without data_sent
        tx_ready = 1'b1;
        start(32'h0A0B_0C0D, 8'h0E);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("abort_valid", 32'(tx_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sent", 32'(data_sent), 32'd0);
        chk("abort_dropped", 32'(dropped), 32'd0);
        chk("abort_data", 32'(tx_data), 32'd0);
        sb_data.delete();
        sb_last.delete();
        exp_sent     = 1'b0;
        exp_dropped  = 0;
        prev_stall   = 1'b0;
        bytes_in_pkt = 0;
        step();
        step();
        rst = 1'b1;
        step();

        // enable=0 ignores events when idle and mid-packet
        enable   = 1'b0;
        new_data = 1'b1;
        for (int i = 0; i < 4; i++) step();
        new_data = 1'b0;
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_valid", 32'(tx_valid), 32'd0);
        chk("dis_dropped", 32'(dropped), 32'd0);
        start(32'h0000_0003, 8'd69);
        step();
        enable   = 1'b0;
        new_data = 1'b1;
        step();
        new_data = 1'b0;
        enable   = 1'b1;
        drain(0);
        step();
        chk("dis_mid_dropped", 32'(dropped), 32'd0);

        chk("sb_empty", 32'(sb_data.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
